// File: rtl/fr_master_pkg.sv
// Shared definitions for the file-register master and its command issuer:
// command codes, command word field positions, stream tags and FSM encodings.
package fr_master_pkg;

    localparam int CMD_W   = 8;
    localparam int DATA_W  = 23;
    localparam int TAG_W   = 4;
    localparam int CMD_LSB = 24;
    localparam int STB_BIT = 23;

    localparam logic [TAG_W-1:0] TAG_MEM = 4'd8;

    typedef enum logic [CMD_W-1:0] {
        CMD_RESET    = 8'd1,
        CMD_EN_TX    = 8'd2,
        CMD_EN_RX    = 8'd3,
        CMD_PH_SEL   = 8'd4,
        CMD_RUN_MEM  = 8'd5,
        CMD_RD_MEM   = 8'd6,
        CMD_IS_FULL  = 8'd7,
        CMD_BER_S_I  = 8'd8,
        CMD_BER_S_Q  = 8'd9,
        CMD_BER_E_I  = 8'd10,
        CMD_BER_E_Q  = 8'd11,
        CMD_BER_HIGH = 8'd12
    } cmd_e;

    typedef struct packed {
        cmd_e              cmd;
        logic [DATA_W-1:0] data;
        logic              rd;
        logic [TAG_W-1:0]  tag;
    } cmd_req_t;

    typedef enum logic [2:0] {
        IS_IDLE, IS_SETUP, IS_STROBE, IS_WAIT, IS_CAP
    } iss_state_e;

    typedef enum logic [3:0] {
        ST_IDLE, ST_RST_ON, ST_RST_OFF, ST_TXEN, ST_RXEN, ST_PHSEL,
        ST_RUNLOG, ST_POLL, ST_BER, ST_MEM, ST_DONE
    } top_state_e;

    // BER readout interleaves each counter read with a HIGH read
    function automatic cmd_e ber_cmd(input logic [2:0] idx);
        cmd_e c;
        if (idx[0]) begin
            c = CMD_BER_HIGH;
        end else begin
            case (idx[2:1])
                2'd0:    c = CMD_BER_S_I;
                2'd1:    c = CMD_BER_S_Q;
                2'd2:    c = CMD_BER_E_I;
                default: c = CMD_BER_E_Q;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/fr_master_issuer.sv
// fr_cmd_issuer: runs one command through SETUP, STROBE, WAIT and CAPTURE and
// holds a read response on the stream until it is accepted.
module fr_cmd_issuer
    import fr_master_pkg::*;
#(
    parameter int NB_GPIOS = 32,
    parameter int NB_C0M   = 8,
    parameter int RSP_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  cmd_req_t            req_i,
    input  logic                ready_i,
    input  logic [NB_GPIOS-1:0] rsp_i,
    output logic [NB_GPIOS-1:0] cmd_o,
    output logic                done_o,
    output logic [31:0]         rsp_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic                valid_o
);

    localparam int STB = NB_GPIOS - NB_C0M - 1;
    localparam int WW  = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;

    iss_state_e          state_q, state_d;
    logic [NB_GPIOS-1:0] cmd_q, cmd_d;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic [31:0]         rsp_q, rsp_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                rd_q, rd_d;
    logic                vld_q, vld_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IS_IDLE;
            cmd_q   <= '0;
            wcnt_q  <= '0;
            rsp_q   <= '0;
            tag_q   <= '0;
            rd_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            wcnt_q  <= wcnt_d;
            rsp_q   <= rsp_d;
            tag_q   <= tag_d;
            rd_q    <= rd_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        wcnt_d  = wcnt_q;
        rsp_d   = rsp_q;
        tag_d   = tag_q;
        rd_d    = rd_q;
        vld_d   = vld_q;
        done_o  = 1'b0;
        case (state_q)
            IS_IDLE: begin
                if (load_i) begin
                    state_d = IS_SETUP;
                    cmd_d   = {NB_C0M'(req_i.cmd), 1'b0, STB'(req_i.data)};
                    rd_d    = req_i.rd;
                    tag_d   = req_i.tag;
                end
            end
            IS_SETUP: begin
                state_d    = IS_STROBE;
                cmd_d[STB] = 1'b1;
            end
            IS_STROBE: begin
                state_d    = IS_WAIT;
                cmd_d[STB] = 1'b0;
                wcnt_d     = '0;
            end
            IS_WAIT: begin
                if (wcnt_q == WW'(RSP_LAT - 1)) begin
                    state_d = IS_CAP;
                    rsp_d   = rsp_i[31:0];
                    vld_d   = rd_q;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            IS_CAP: begin
                // A pending read blocks the next SETUP until the stream takes it
                if (!vld_q || ready_i) begin
                    done_o = 1'b1;
                    vld_d  = 1'b0;
                    if (load_i) begin
                        state_d = IS_SETUP;
                        cmd_d   = {NB_C0M'(req_i.cmd), 1'b0, STB'(req_i.data)};
                        rd_d    = req_i.rd;
                        tag_d   = req_i.tag;
                    end else begin
                        state_d = IS_IDLE;
                        cmd_d   = '0;
                    end
                end
            end
            default: state_d = IS_IDLE;
        endcase
    end

    assign cmd_o   = cmd_q;
    assign rsp_o   = rsp_q;
    assign tag_o   = tag_q;
    assign valid_o = vld_q;

endmodule

// File: rtl/fr_master.sv
// fr_master: sequences the file-register bring-up, log fill polling, BER readout
// and log memory dump through fr_cmd_issuer, streaming read results out.
module fr_master
    import fr_master_pkg::*;
#(
    parameter int NB_GPIOS  = 32,
    parameter int NB_C0M    = 8,
    parameter int RAM_DEPTH = 1024,
    parameter int RSP_LAT   = 2,
    parameter int POLL_MAX  = 65535
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_start,
    input  logic [1:0]          i_phase,
    output logic [NB_GPIOS-1:0] o_cmd_to_fr,
    input  logic [NB_GPIOS-1:0] i_data_from_fr,
    output logic [31:0]         o_data,
    output logic [3:0]          o_tag,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_timeout
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int PW = $clog2(POLL_MAX + 1);

    top_state_e    state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [2:0]    ber_q, ber_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          tmo_q, tmo_d;
    logic          load;
    logic          iss_done;
    cmd_req_t      req;

    function automatic cmd_req_t build_req(input top_state_e s, input logic [2:0] b,
                                           input logic [AW-1:0] a, input logic [1:0] ph);
        cmd_req_t r;
        r.cmd  = CMD_RESET;
        r.data = '0;
        r.rd   = 1'b0;
        r.tag  = '0;
        case (s)
            ST_RST_ON:  r.data = DATA_W'(1);
            ST_TXEN:    begin r.cmd = CMD_EN_TX;   r.data = DATA_W'(1);  end
            ST_RXEN:    begin r.cmd = CMD_EN_RX;   r.data = DATA_W'(1);  end
            ST_PHSEL:   begin r.cmd = CMD_PH_SEL;  r.data = DATA_W'(ph); end
            ST_RUNLOG:  begin r.cmd = CMD_RUN_MEM; r.data = DATA_W'(1);  end
            ST_POLL:    r.cmd = CMD_IS_FULL;
            ST_BER: begin
                r.cmd = ber_cmd(b);
                r.rd  = 1'b1;
                r.tag = TAG_W'(b);
            end
            ST_MEM: begin
                r.cmd  = CMD_RD_MEM;
                r.data = DATA_W'(a);
                r.rd   = 1'b1;
                r.tag  = TAG_MEM;
            end
            default: ;
        endcase
        return r;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            poll_q  <= '0;
            ber_q   <= '0;
            addr_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            ber_q   <= ber_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        poll_d  = poll_q;
        ber_d   = ber_q;
        addr_d  = addr_q;
        tmo_d   = tmo_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d = ST_RST_ON;
                    poll_d  = '0;
                    ber_d   = '0;
                    addr_d  = '0;
                    tmo_d   = 1'b0;
                    load    = 1'b1;
                end
            end
            default: begin
                if (iss_done) begin
                    case (state_q)
                        ST_RST_ON:  state_d = ST_RST_OFF;
                        ST_RST_OFF: state_d = ST_TXEN;
                        ST_TXEN:    state_d = ST_RXEN;
                        ST_RXEN:    state_d = ST_PHSEL;
                        ST_PHSEL:   state_d = ST_RUNLOG;
                        ST_RUNLOG: begin
                            state_d = ST_POLL;
                            poll_d  = '0;
                        end
                        ST_POLL: begin
                            // full wins over timeout on the last allowed poll
                            if (o_data[0]) begin
                                state_d = ST_BER;
                                ber_d   = '0;
                            end else if (poll_q == PW'(POLL_MAX - 1)) begin
                                state_d = ST_DONE;
                                tmo_d   = 1'b1;
                            end else begin
                                poll_d = poll_q + PW'(1);
                            end
                        end
                        ST_BER: begin
                            if (ber_q == 3'd7) begin
                                state_d = ST_MEM;
                                addr_d  = '0;
                            end else begin
                                ber_d = ber_q + 3'd1;
                            end
                        end
                        ST_MEM: begin
                            if (addr_q == AW'(RAM_DEPTH - 1)) state_d = ST_DONE;
                            else                              addr_d  = addr_q + AW'(1);
                        end
                        default: state_d = ST_IDLE;
                    endcase
                    load = (state_d != ST_DONE) && (state_d != ST_IDLE);
                end
            end
        endcase
        req = build_req(state_d, ber_d, addr_d, i_phase);
    end

    fr_cmd_issuer #(
        .NB_GPIOS(NB_GPIOS),
        .NB_C0M  (NB_C0M),
        .RSP_LAT (RSP_LAT)
    ) u_issuer (
        .clk    (clock),
        .rst    (reset),
        .load_i (load),
        .req_i  (req),
        .ready_i(i_ready),
        .rsp_i  (i_data_from_fr),
        .cmd_o  (o_cmd_to_fr),
        .done_o (iss_done),
        .rsp_o  (o_data),
        .tag_o  (o_tag),
        .valid_o(o_valid)
    );

    assign o_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done    = (state_q == ST_DONE);
    assign o_timeout = tmo_q;

endmodule

// File: tb/tb_fr_master.sv
// Directed bench for fr_master with a behavioural file-register responder.
module tb_fr_master;
    import fr_master_pkg::*;

    localparam int NB    = 32;
    localparam int DEPTH = 64;
    localparam int PMAX  = 4;
    localparam int LAT   = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          i_start = 1'b0;
    logic [1:0]    i_phase = 2'd0;
    logic          i_ready = 1'b1;
    logic [NB-1:0] i_data_from_fr;
    logic [NB-1:0] o_cmd_to_fr;
    logic [31:0]   o_data;
    logic [3:0]    o_tag;
    logic          o_valid, o_busy, o_done, o_timeout;

    fr_master #(
        .NB_GPIOS(NB), .NB_C0M(8), .RAM_DEPTH(DEPTH), .RSP_LAT(LAT), .POLL_MAX(PMAX)
    ) dut (
        .clock(clock), .reset(reset), .i_start(i_start), .i_phase(i_phase),
        .o_cmd_to_fr(o_cmd_to_fr), .i_data_from_fr(i_data_from_fr),
        .o_data(o_data), .o_tag(o_tag), .o_valid(o_valid), .i_ready(i_ready),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int full_after = 0;
    int poll_seen = 0, poll_base = 0;
    int ber_seen = 0, ber_base = 0;
    int cmd_base = 0, str_base = 0;
    logic [31:0] ber_resp = 32'd0;
    logic        prev_stb = 1'b0;
    logic [31:0] cmd_log[$];
    int          stb_t[$];
    logic [35:0] str_log[$];
    logic [31:0] exp_cmd[$];
    logic [35:0] exp_str[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Strobe/stream monitor plus responder state, sampled on the falling edge
    always @(negedge clock) begin
        if (o_cmd_to_fr[STB_BIT] && !prev_stb) begin
            cmd_log.push_back(o_cmd_to_fr & ~(32'h1 << STB_BIT));
            stb_t.push_back(cyc);
            if (o_cmd_to_fr[31:24] == 8'd7) poll_seen = poll_seen + 1;
            if (o_cmd_to_fr[31:24] >= 8'd8 && o_cmd_to_fr[31:24] <= 8'd12) begin
                ber_resp = 32'(32'hA0 + (ber_seen - ber_base));
                ber_seen = ber_seen + 1;
            end
        end
        prev_stb = o_cmd_to_fr[STB_BIT];
        if (o_valid && i_ready) str_log.push_back({o_tag, o_data});
    end

    always_comb begin
        i_data_from_fr = '0;
        case (o_cmd_to_fr[31:24])
            8'd7: i_data_from_fr = {31'd0, (full_after != 0) && ((poll_seen - poll_base) >= full_after)};
            8'd8, 8'd9, 8'd10, 8'd11, 8'd12: i_data_from_fr = ber_resp;
            8'd6: i_data_from_fr = {8'h5A, 1'b0, o_cmd_to_fr[22:0]};
            default: ;
        endcase
    end

    function automatic logic [31:0] cmdw(input logic [7:0] c, input logic [22:0] d);
        return {c, 1'b0, d};
    endfunction

    function automatic int ber_code(input int k);
        return (k % 2 == 1) ? 12 : 8 + k / 2;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic start_run(input logic [1:0] ph, input int fa);
        cmd_base   = cmd_log.size();
        str_base   = str_log.size();
        poll_base  = poll_seen;
        ber_base   = ber_seen;
        full_after = fa;
        i_phase    = ph;
        @(posedge clock); #1 i_start = 1'b1;
        @(posedge clock); #1 i_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 5000 && !o_done; k++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check_run(input string nm, input logic [1:0] ph, input int polls,
                             input bit tmo, input bit thru);
        int bad;
        int ns;
        logic [31:0] a, b;
        exp_cmd.delete();
        exp_str.delete();
        exp_cmd.push_back(cmdw(8'd1, 23'd1));
        exp_cmd.push_back(cmdw(8'd1, 23'd0));
        exp_cmd.push_back(cmdw(8'd2, 23'd1));
        exp_cmd.push_back(cmdw(8'd3, 23'd1));
        exp_cmd.push_back(cmdw(8'd4, 23'(ph)));
        exp_cmd.push_back(cmdw(8'd5, 23'd1));
        for (int i = 0; i < polls; i++) exp_cmd.push_back(cmdw(8'd7, 23'd0));
        if (!tmo) begin
            for (int k = 0; k < 8; k++) begin
                exp_cmd.push_back(cmdw(8'(ber_code(k)), 23'd0));
                exp_str.push_back({4'(k), 32'(32'hA0 + k)});
            end
            for (int ad = 0; ad < DEPTH; ad++) begin
                exp_cmd.push_back(cmdw(8'd6, 23'(ad)));
                exp_str.push_back({4'd8, 32'(32'h5A00_0000 + ad)});
            end
        end
        chk({nm, " done"},    64'(o_done),    64'(1'b1));
        chk({nm, " timeout"}, 64'(o_timeout), 64'(tmo));
        chk({nm, " busy"},    64'(o_busy),    64'(1'b0));
        chk({nm, " polls"},   64'(poll_seen - poll_base), 64'(polls));
        chk({nm, " ncmd"},    64'(cmd_log.size() - cmd_base), 64'(exp_cmd.size()));
        chk({nm, " nstream"}, 64'(str_log.size() - str_base), 64'(exp_str.size()));
        bad = -1;
        for (int i = 0; i < exp_cmd.size() && cmd_base + i < cmd_log.size(); i++)
            if (bad < 0 && cmd_log[cmd_base + i] !== exp_cmd[i]) bad = i;
        n_chk++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s cmd[%0d]: got %h want %h", nm, bad, cmd_log[cmd_base + bad], exp_cmd[bad]);
        end
        bad = -1;
        for (int i = 0; i < exp_str.size() && str_base + i < str_log.size(); i++)
            if (bad < 0 && str_log[str_base + i] !== exp_str[i]) bad = i;
        n_chk++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s stream[%0d]: got %h want %h", nm, bad, str_log[str_base + bad], exp_str[bad]);
        end
        if (thru && !tmo) begin
            bad = -1;
            ns = 0;
            for (int i = cmd_base + 1; i < cmd_log.size(); i++) begin
                a = cmd_log[i - 1];
                b = cmd_log[i];
                if (a[31:24] == 8'd6 && b[31:24] == 8'd6) begin
                    ns++;
                    if (bad < 0 && stb_t[i] - stb_t[i - 1] != 3 + LAT) bad = stb_t[i] - stb_t[i - 1];
                end
            end
            chk({nm, " rdmem_pairs"}, 64'(ns), 64'(DEPTH - 1));
            chk({nm, " read_period"}, 64'(bad), 64'(-1));
        end
    endtask

    typedef struct {
        logic [1:0] ph;
        int         fa;
        int         polls;
        bit         tmo;
    } scen_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t tbl[4];
        logic [31:0] hold_d;
        logic [3:0]  hold_t;
        int          ncmd;
        bit          ok, seen;

        tbl[0] = '{ph: 2'd2, fa: 3, polls: 3, tmo: 1'b0};
        tbl[1] = '{ph: 2'd1, fa: 1, polls: 1, tmo: 1'b0};
        tbl[2] = '{ph: 2'd3, fa: 0, polls: 4, tmo: 1'b1};
        tbl[3] = '{ph: 2'd0, fa: 4, polls: 4, tmo: 1'b0};

        repeat (3) @(posedge clock);
        #1;
        chk("rst cmd",     64'(o_cmd_to_fr), 64'd0);
        chk("rst data",    64'(o_data),      64'd0);
        chk("rst tag",     64'(o_tag),       64'd0);
        chk("rst valid",   64'(o_valid),     64'd0);
        chk("rst busy",    64'(o_busy),      64'd0);
        chk("rst done",    64'(o_done),      64'd0);
        chk("rst timeout", 64'(o_timeout),   64'd0);
        reset = 1'b0;

        for (int s = 0; s < 4; s++) begin
            start_run(tbl[s].ph, tbl[s].fa);
            chk($sformatf("scen%0d busy", s), 64'(o_busy), 64'd1);
            wait_done();
            check_run($sformatf("scen%0d", s), tbl[s].ph, tbl[s].polls, tbl[s].tmo, 1'b1);
        end

        // Backpressure on MEM address 5 for 20 cycles
        start_run(2'd1, 2);
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(posedge clock); #1;
            if (o_valid && o_tag == 4'd8 && o_data[22:0] == 23'd5) seen = 1'b1;
        end
        chk("bp reached", 64'(seen), 64'd1);
        i_ready = 1'b0;
        hold_d = o_data;
        hold_t = o_tag;
        ncmd   = cmd_log.size();
        ok     = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (o_data !== hold_d || o_tag !== hold_t || o_valid !== 1'b1) ok = 1'b0;
        end
        chk("bp stable",   64'(ok),                    64'd1);
        chk("bp nostrobe", 64'(cmd_log.size() - ncmd), 64'd0);
        chk("bp data",     64'(hold_d),                64'h5A00_0005);
        @(posedge clock); #1 i_ready = 1'b1;
        wait_done();
        check_run("bp", 2'd1, 2, 1'b0, 1'b0);

        // i_start during BER must not disturb the run
        start_run(2'd0, 1);
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clock);
            if (cmd_log.size() > cmd_base && cmd_log[cmd_log.size() - 1] == cmdw(8'd9, 23'd0)) seen = 1'b1;
        end
        chk("ber reached", 64'(seen), 64'd1);
        @(posedge clock); #1 i_start = 1'b1;
        @(posedge clock); #1 i_start = 1'b0;
        chk("ber busy", 64'(o_busy), 64'd1);
        wait_done();
        check_run("startber", 2'd0, 1, 1'b0, 1'b1);

        // Reset at MEM address 37, then a clean restart
        start_run(2'd3, 3);
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clock);
            if (cmd_log.size() > cmd_base && cmd_log[cmd_log.size() - 1] == cmdw(8'd6, 23'd37)) seen = 1'b1;
        end
        chk("a37 reached", 64'(seen), 64'd1);
        @(posedge clock); #1 reset = 1'b1;
        #1;
        chk("abort cmd",   64'(o_cmd_to_fr), 64'd0);
        chk("abort valid", 64'(o_valid),     64'd0);
        chk("abort busy",  64'(o_busy),      64'd0);
        chk("abort done",  64'(o_done),      64'd0);
        @(posedge clock); #1 reset = 1'b0;
        start_run(2'd3, 3);
        wait_done();
        check_run("restart", 2'd3, 3, 1'b0, 1'b1);

        // Restart straight from DONE clears sticky status
        start_run(2'd2, 0);
        wait_done();
        check_run("tmo2", 2'd2, 4, 1'b1, 1'b0);
        start_run(2'd2, 2);
        chk("redone clr done", 64'(o_done),    64'd0);
        chk("redone clr tmo",  64'(o_timeout), 64'd0);
        wait_done();
        check_run("redone", 2'd2, 2, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fr_master.md
FR_MASTER -- requirements
Module: fr_master

Interface
REQ-001 Parameter NB_GPIOS, default 32: width of command and response words.
REQ-002 Parameter NB_C0M, default 8: command field width, bits [31:24].
REQ-003 Parameter RAM_DEPTH, default 1024: log entries read back.
REQ-004 Parameter RSP_LAT, default 2: cycles from strobe rise to response capture.
REQ-005 Parameter POLL_MAX, default 65535: maximum IS_FULL polls before timeout.
REQ-006 clock  in  1  single system clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 i_start  in  1  one-cycle pulse; starts a run while idle.
REQ-009 i_phase  in  2  sampling offset sent with PH_SEL.
REQ-010 o_cmd_to_fr  out  NB_GPIOS  command word: cmd[31:24], strobe[23], data[22:0].
REQ-011 i_data_from_fr  in  NB_GPIOS  file-register response word.
REQ-012 o_data / o_tag / o_valid  out  32 / 4 / 1  captured response stream.
REQ-013 i_ready  in  1  stream backpressure.
REQ-014 o_busy / o_done / o_timeout  out  1 / 1 / 1  run status; done and timeout are sticky until next i_start.

Function
REQ-015 Every command SHALL use 3 phases: SETUP (word, strobe=0, 1 cycle), STROBE (strobe=1, 1 cycle), WAIT (strobe=0, RSP_LAT cycles), then CAPTURE i_data_from_fr.
REQ-016 The top FSM SHALL step through IDLE, RST_ON (RESET, data=1), RST_OFF (RESET, data=0), TXEN (EN_TX, 1), RXEN (EN_RX, 1), PHSEL (PH_SEL, i_phase), RUNLOG (RUN_MEM, 1), POLL, BER, MEM, DONE.
REQ-017 Command codes SHALL be RESET=1, EN_TX=2, EN_RX=3, PH_SEL=4, RUN_MEM=5, RD_MEM=6, IS_FULL=7, BER_S_I=8, BER_S_Q=9, BER_E_I=10, BER_E_Q=11, BER_HIGH=12.
REQ-018 POLL SHALL issue IS_FULL repeatedly and exit to BER when captured bit 0 is 1.
REQ-019 POLL SHALL exit to DONE with o_timeout=1 after POLL_MAX polls without bit 0 set.
REQ-020 BER SHALL issue 8 reads in order S_I, HIGH, S_Q, HIGH, E_I, HIGH, E_Q, HIGH.
REQ-021 BER reads SHALL use tags 0..7 in that order.
REQ-022 MEM SHALL issue RD_MEM with data = address 0..RAM_DEPTH-1, tag 8 for every entry.
REQ-023 Write commands (RST..RUNLOG, POLL) SHALL NOT produce stream output.
REQ-024 A read capture SHALL assert o_valid with o_data/o_tag held stable until the i_ready handshake.
REQ-025 The next command SHALL NOT start SETUP until the pending stream word is accepted.
REQ-026 Throughput with i_ready=1 SHALL be one read per 3+RSP_LAT cycles; no read is dropped or duplicated.
REQ-027 The address counter SHALL be clog2(RAM_DEPTH) bits wide and SHALL NOT wrap.
REQ-028 MEM SHALL go to DONE after address RAM_DEPTH-1 is accepted.
REQ-029 i_start SHALL be ignored while o_busy=1.
REQ-030 o_busy SHALL be 1 in every state except IDLE and DONE.
REQ-031 i_start in DONE SHALL clear o_done/o_timeout and restart at RST_ON.
REQ-032 o_done SHALL set on entry to DONE, including on timeout.

Reset
REQ-033 On reset, all outputs SHALL go to 0: o_cmd_to_fr, o_data, o_tag, o_valid, o_busy, o_done, o_timeout.
REQ-034 On reset, the FSMs SHALL go to IDLE, and the counters and the poll counter SHALL clear.
REQ-035 Reset mid-run SHALL abort immediately; any pending stream word SHALL be discarded.

Structure
REQ-036 Command codes, field bit positions and tag values SHALL live in the shared package used by file_register.
REQ-037 The per-command SETUP/STROBE/WAIT/CAPTURE handshake SHALL be one sub-module, fr_cmd_issuer, with a start/done interface.
REQ-038 The top FSM SHALL sequence fr_cmd_issuer.

Verification
REQ-039 i_start, i_phase=2, i_ready=1, responder returns full on the 3rd poll -> commands 01/000001, 01/000000, 02/1, 03/1, 04/2, 05/1, then 3 IS_FULL strobes.
REQ-040 Responder returns tag-dependent value 0xA0+k -> BER stream is tags 0..7 with data 0xA0..0xA7, then RAM_DEPTH tag-8 words, then o_done=1.
REQ-041 i_ready held 0 for 20 cycles during MEM -> o_data/o_tag stable, no new strobe, resumes with the same next address.
REQ-042 Full never asserted, POLL_MAX=4 -> exactly 4 IS_FULL strobes, o_timeout=1, o_done=1, no stream output.
REQ-043 Reset asserted at MEM address 37 -> o_cmd_to_fr=0 and o_valid=0 immediately; a new i_start restarts at RST_ON.
REQ-044 i_start pulsed during BER -> ignored, sequence unchanged.
